// File: rtl/jtag_tap_target.sv
// jtag_tap_target
// ---------------------------------------------------------------------------
// Target-side JTAG TAP responder. TCK/TMS/TDI are oversampled in the CLK
// domain; every TAP action happens on a single-CLK strobe derived from the
// synchronised TCK edges. Implements the IEEE 1149.1 16-state controller, an
// IR_LEN-bit instruction register, BYPASS, IDCODE and one user data register
// with a parallel capture/update interface.
//
// Ports
//   CLK               system clock, must run at least 8x TCK
//   RESET             synchronous, active-high reset
//   TCK, TMS, TDI     asynchronous JTAG pins from the master
//   TDO               test data out (0 whenever TDO_OE is low)
//   TDO_OE            high while in Shift-IR / Shift-DR
//   USR_CAPTURE_DATA  parallel value loaded into the user DR at Capture-DR
//   USR_CAPTURE       one-CLK pulse when USR_CAPTURE_DATA is sampled
//   USR_UPDATE_DATA   last user DR value committed at Update-DR
//   USR_UPDATE_VALID  one-CLK pulse when USR_UPDATE_DATA is written
//   TAP_STATE         current TAP state (same encoding as the master PHY)
//   IR_OUT            active instruction
// ---------------------------------------------------------------------------
module jtag_tap_target #(
  parameter int                IR_LEN     = 4,
  parameter logic [31:0]       IDCODE_VAL = 32'h1BA01477,
  parameter logic [IR_LEN-1:0] IDCODE_IR  = 4'hE,
  parameter logic [IR_LEN-1:0] USER_IR    = 4'hA,
  parameter int                USER_DR_W  = 35
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 TCK,
  input  logic                 TMS,
  input  logic                 TDI,
  output logic                 TDO,
  output logic                 TDO_OE,
  input  logic [USER_DR_W-1:0] USR_CAPTURE_DATA,
  output logic                 USR_CAPTURE,
  output logic [USER_DR_W-1:0] USR_UPDATE_DATA,
  output logic                 USR_UPDATE_VALID,
  output logic [3:0]           TAP_STATE,
  output logic [IR_LEN-1:0]    IR_OUT
);

  // TAP state encoding shared with the master PHY: IR states are the DR
  // states with bit 3 set.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0000,
    ST_SEL_DR    = 4'b0001,
    ST_SHIFT_DR  = 4'b0010,
    ST_UPDATE_DR = 4'b0011,
    ST_CAP_DR    = 4'b0100,
    ST_EXIT1_DR  = 4'b0101,
    ST_PAUSE_DR  = 4'b0110,
    ST_EXIT2_DR  = 4'b0111,
    ST_RESET     = 4'b1000,
    ST_SEL_IR    = 4'b1001,
    ST_SHIFT_IR  = 4'b1010,
    ST_UPDATE_IR = 4'b1011,
    ST_CAP_IR    = 4'b1100,
    ST_EXIT1_IR  = 4'b1101,
    ST_PAUSE_IR  = 4'b1110,
    ST_EXIT2_IR  = 4'b1111
  } tap_state_t;

  // ------------------------------------------------------------------------
  // Pin synchronisers: bit 0 = TCK, bit 1 = TMS, bit 2 = TDI.
  // TMS resets high so a reset never looks like a TMS=0 request.
  // ------------------------------------------------------------------------
  localparam logic [2:0] SYNC_RST = 3'b010;

  logic [2:0] pin_vec;
  assign pin_vec = {TDI, TMS, TCK};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic s1_reg;
    logic s2_reg;
    always_ff @(posedge CLK) begin
      if (RESET) begin
        s1_reg <= SYNC_RST[gi];
        s2_reg <= SYNC_RST[gi];
      end else begin
        s1_reg <= pin_vec[gi];
        s2_reg <= s1_reg;
      end
    end
  end

  logic tck_s2;
  logic tms_s2;
  logic tdi_s2;
  logic tck3_reg;
  logic tck_rise;
  logic tck_fall;

  assign tck_s2 = g_sync[0].s2_reg;
  assign tms_s2 = g_sync[1].s2_reg;
  assign tdi_s2 = g_sync[2].s2_reg;

  always_ff @(posedge CLK) begin
    if (RESET) tck3_reg <= 1'b0;
    else       tck3_reg <= tck_s2;
  end

  // TMS/TDI share TCK's synchroniser depth, so sampling stage 2 on the
  // rise strobe sees the values that were stable around the pin edge.
  assign tck_rise = tck_s2 & ~tck3_reg;
  assign tck_fall = ~tck_s2 & tck3_reg;

  // ------------------------------------------------------------------------
  // TAP controller
  // ------------------------------------------------------------------------
  tap_state_t state_reg;
  tap_state_t state_next;

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= ST_RESET;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (tck_rise) begin
      case (state_reg)
        ST_RESET:     state_next = tms_s2 ? ST_RESET     : ST_IDLE;
        ST_IDLE:      state_next = tms_s2 ? ST_SEL_DR    : ST_IDLE;
        ST_SEL_DR:    state_next = tms_s2 ? ST_SEL_IR    : ST_CAP_DR;
        ST_SEL_IR:    state_next = tms_s2 ? ST_RESET     : ST_CAP_IR;
        ST_CAP_DR:    state_next = tms_s2 ? ST_EXIT1_DR  : ST_SHIFT_DR;
        ST_SHIFT_DR:  state_next = tms_s2 ? ST_EXIT1_DR  : ST_SHIFT_DR;
        ST_EXIT1_DR:  state_next = tms_s2 ? ST_UPDATE_DR : ST_PAUSE_DR;
        ST_PAUSE_DR:  state_next = tms_s2 ? ST_EXIT2_DR  : ST_PAUSE_DR;
        ST_EXIT2_DR:  state_next = tms_s2 ? ST_UPDATE_DR : ST_SHIFT_DR;
        ST_UPDATE_DR: state_next = tms_s2 ? ST_SEL_DR    : ST_IDLE;
        ST_CAP_IR:    state_next = tms_s2 ? ST_EXIT1_IR  : ST_SHIFT_IR;
        ST_SHIFT_IR:  state_next = tms_s2 ? ST_EXIT1_IR  : ST_SHIFT_IR;
        ST_EXIT1_IR:  state_next = tms_s2 ? ST_UPDATE_IR : ST_PAUSE_IR;
        ST_PAUSE_IR:  state_next = tms_s2 ? ST_EXIT2_IR  : ST_PAUSE_IR;
        ST_EXIT2_IR:  state_next = tms_s2 ? ST_UPDATE_IR : ST_SHIFT_IR;
        ST_UPDATE_IR: state_next = tms_s2 ? ST_SEL_DR    : ST_IDLE;
        default:      state_next = ST_RESET;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Instruction decode; anything that is not IDCODE or USER is BYPASS.
  // ------------------------------------------------------------------------
  logic [IR_LEN-1:0] ir_reg;
  logic              sel_id;
  logic              sel_user;

  assign sel_id   = (ir_reg == IDCODE_IR);
  assign sel_user = (ir_reg == USER_IR);

  // ------------------------------------------------------------------------
  // Shift registers. Each DR has its own register so PAUSE simply means
  // "no strobe reaches the shifter" and the bitstream resumes intact.
  // ------------------------------------------------------------------------
  logic [IR_LEN-1:0]    ir_sr;
  logic [31:0]          id_sr;
  logic [USER_DR_W-1:0] user_sr;
  logic                 byp_sr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_sr   <= '0;
      id_sr   <= '0;
      user_sr <= '0;
      byp_sr  <= 1'b0;
    end else if (tck_rise) begin
      case (state_reg)
        ST_CAP_IR:   ir_sr <= IR_LEN'(2'b01);
        ST_SHIFT_IR: ir_sr <= {tdi_s2, ir_sr[IR_LEN-1:1]};
        ST_CAP_DR: begin
          if (sel_id)        id_sr   <= IDCODE_VAL;
          else if (sel_user) user_sr <= USR_CAPTURE_DATA;
          else               byp_sr  <= 1'b0;
        end
        ST_SHIFT_DR: begin
          if (sel_id)        id_sr   <= {tdi_s2, id_sr[31:1]};
          else if (sel_user) user_sr <= {tdi_s2, user_sr[USER_DR_W-1:1]};
          else               byp_sr  <= tdi_s2;
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Active instruction: reloaded with IDCODE whenever the controller is
  // heading into Test-Logic-Reset, committed from ir_sr on Update-IR fall.
  // ------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_reg <= IDCODE_IR;
    end else if (tck_rise && (state_next == ST_RESET)) begin
      ir_reg <= IDCODE_IR;
    end else if (tck_fall && (state_reg == ST_UPDATE_IR)) begin
      ir_reg <= ir_sr;
    end
  end

  // ------------------------------------------------------------------------
  // TDO launches on the falling edge so the master can sample on the rise.
  // ------------------------------------------------------------------------
  logic shifting;
  logic sel_lsb;

  always_comb begin
    shifting = (state_reg == ST_SHIFT_IR) || (state_reg == ST_SHIFT_DR);
    sel_lsb  = byp_sr;
    if (state_reg == ST_SHIFT_IR) sel_lsb = ir_sr[0];
    else if (sel_id)              sel_lsb = id_sr[0];
    else if (sel_user)            sel_lsb = user_sr[0];
  end

  logic tdo_reg;
  logic tdo_oe_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tdo_reg    <= 1'b0;
      tdo_oe_reg <= 1'b0;
    end else if (tck_fall) begin
      tdo_oe_reg <= shifting;
      tdo_reg    <= shifting & sel_lsb;
    end
  end

  // ------------------------------------------------------------------------
  // User capture/update handshake
  // ------------------------------------------------------------------------
  logic                 usr_capture_reg;
  logic                 usr_update_valid_reg;
  logic [USER_DR_W-1:0] usr_update_data_reg;
  logic                 do_update;

  assign do_update = tck_fall && (state_reg == ST_UPDATE_DR) && sel_user;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      usr_capture_reg      <= 1'b0;
      usr_update_valid_reg <= 1'b0;
      usr_update_data_reg  <= '0;
    end else begin
      // Pulses in the same CLK that user_sr samples USR_CAPTURE_DATA.
      usr_capture_reg      <= tck_rise && (state_reg == ST_CAP_DR) && sel_user;
      usr_update_valid_reg <= do_update;
      if (do_update) usr_update_data_reg <= user_sr;
    end
  end

  assign TDO              = tdo_reg;
  assign TDO_OE           = tdo_oe_reg;
  assign USR_CAPTURE      = usr_capture_reg;
  assign USR_UPDATE_VALID = usr_update_valid_reg;
  assign USR_UPDATE_DATA  = usr_update_data_reg;
  assign TAP_STATE        = state_reg;
  assign IR_OUT           = ir_reg;

endmodule

// File: tb/tb_jtag_tap_target.sv
// tb_jtag_tap_target
// Drives the JTAG pins at TCK = CLK/12 and checks the target against a
// behavioural TAP model (transition tables plus integer shift registers).
module tb_jtag_tap_target;

  localparam int IR_LEN    = 4;
  localparam int USER_DR_W = 35;

  // TAP state codes as seen on TAP_STATE
  localparam logic [3:0] T_IDLE   = 4'h0;
  localparam logic [3:0] T_SEL_DR = 4'h1;
  localparam logic [3:0] T_SHIFT  = 4'h2;
  localparam logic [3:0] T_UPDATE = 4'h3;
  localparam logic [3:0] T_CAP    = 4'h4;
  localparam logic [3:0] T_EXIT1  = 4'h5;
  localparam logic [3:0] T_PAUSE  = 4'h6;
  localparam logic [3:0] T_EXIT2  = 4'h7;
  localparam logic [3:0] T_RESET  = 4'h8;
  localparam logic [3:0] T_SEL_IR = 4'h9;
  localparam logic [3:0] IRBIT    = 4'h8;

  logic                 CLK = 1'b0;
  logic                 RESET = 1'b1;
  logic                 TCK = 1'b0;
  logic                 TMS = 1'b1;
  logic                 TDI = 1'b0;
  logic                 TDO;
  logic                 TDO_OE;
  logic [USER_DR_W-1:0] USR_CAPTURE_DATA = '0;
  logic                 USR_CAPTURE;
  logic [USER_DR_W-1:0] USR_UPDATE_DATA;
  logic                 USR_UPDATE_VALID;
  logic [3:0]           TAP_STATE;
  logic [IR_LEN-1:0]    IR_OUT;

  always #5 CLK = ~CLK;

  jtag_tap_target #(
    .IR_LEN(4), .IDCODE_VAL(32'h1BA01477), .IDCODE_IR(4'hE),
    .USER_IR(4'hA), .USER_DR_W(35)
  ) dut (
    .CLK(CLK), .RESET(RESET), .TCK(TCK), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .TDO_OE(TDO_OE),
    .USR_CAPTURE_DATA(USR_CAPTURE_DATA), .USR_CAPTURE(USR_CAPTURE),
    .USR_UPDATE_DATA(USR_UPDATE_DATA), .USR_UPDATE_VALID(USR_UPDATE_VALID),
    .TAP_STATE(TAP_STATE), .IR_OUT(IR_OUT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // CLK cycles each strobe output was seen high
  int cap_seen = 0;
  int upd_seen = 0;
  always @(negedge CLK) begin
    if (USR_CAPTURE === 1'b1)      cap_seen++;
    if (USR_UPDATE_VALID === 1'b1) upd_seen++;
  end

  // ---------------- behavioural model ----------------
  logic [3:0]  tr0 [16];
  logic [3:0]  tr1 [16];
  logic [3:0]  m_state;
  logic [3:0]  m_ir;
  logic [3:0]  m_ir_sr;
  logic [31:0] m_id;
  logic [34:0] m_user;
  logic        m_byp;
  logic        m_tdo;
  logic        m_oe;
  logic [34:0] m_upd;
  int          m_cap_n;
  int          m_upd_n;

  task automatic build_tables();
    for (int b = 0; b < 2; b++) begin
      logic [3:0] base;
      base = (b == 1) ? IRBIT : 4'h0;
      tr0[base|T_CAP]    = base|T_SHIFT;  tr1[base|T_CAP]    = base|T_EXIT1;
      tr0[base|T_SHIFT]  = base|T_SHIFT;  tr1[base|T_SHIFT]  = base|T_EXIT1;
      tr0[base|T_EXIT1]  = base|T_PAUSE;  tr1[base|T_EXIT1]  = base|T_UPDATE;
      tr0[base|T_PAUSE]  = base|T_PAUSE;  tr1[base|T_PAUSE]  = base|T_EXIT2;
      tr0[base|T_EXIT2]  = base|T_SHIFT;  tr1[base|T_EXIT2]  = base|T_UPDATE;
      tr0[base|T_UPDATE] = T_IDLE;        tr1[base|T_UPDATE] = T_SEL_DR;
    end
    tr0[T_RESET]  = T_IDLE;       tr1[T_RESET]  = T_RESET;
    tr0[T_IDLE]   = T_IDLE;       tr1[T_IDLE]   = T_SEL_DR;
    tr0[T_SEL_DR] = T_CAP;        tr1[T_SEL_DR] = T_SEL_IR;
    tr0[T_SEL_IR] = IRBIT|T_CAP;  tr1[T_SEL_IR] = T_RESET;
  endtask

  // 0 = bypass, 1 = idcode, 2 = user
  function automatic int kind_of(logic [3:0] ir);
    if (ir == 4'hE) return 1;
    if (ir == 4'hA) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = T_RESET; m_ir = 4'hE; m_ir_sr = '0; m_id = '0; m_user = '0;
    m_byp = 1'b0; m_tdo = 1'b0; m_oe = 1'b0; m_upd = '0;
  endtask

  task automatic model_rise(input logic tms, input logic tdi);
    int k;
    k = kind_of(m_ir);
    if (m_state == (IRBIT|T_CAP)) m_ir_sr = 4'd1;
    if (m_state == (IRBIT|T_SHIFT)) m_ir_sr = (m_ir_sr >> 1) | (4'(tdi) << 3);
    if (m_state == T_CAP) begin
      if (k == 1) m_id = 32'h1BA01477;
      else if (k == 2) begin m_user = USR_CAPTURE_DATA; m_cap_n++; end
      else m_byp = 1'b0;
    end
    if (m_state == T_SHIFT) begin
      if (k == 1)      m_id   = (m_id >> 1)   | (32'(tdi) << 31);
      else if (k == 2) m_user = (m_user >> 1) | (35'(tdi) << 34);
      else             m_byp  = tdi;
    end
    m_state = tms ? tr1[m_state] : tr0[m_state];
    if (m_state == T_RESET) m_ir = 4'hE;
  endtask

  task automatic model_fall();
    int k;
    k = kind_of(m_ir);
    m_tdo = 1'b0; m_oe = 1'b0;
    if (m_state == (IRBIT|T_SHIFT)) begin m_oe = 1'b1; m_tdo = m_ir_sr[0]; end
    if (m_state == T_SHIFT) begin
      m_oe  = 1'b1;
      m_tdo = (k == 1) ? m_id[0] : (k == 2) ? m_user[0] : m_byp;
    end
    if (m_state == (IRBIT|T_UPDATE)) m_ir = m_ir_sr;
    if (m_state == T_UPDATE && k == 2) begin m_upd = m_user; m_upd_n++; end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("tap_state",   64'(TAP_STATE),       64'(m_state));
    chk("ir_out",      64'(IR_OUT),          64'(m_ir));
    chk("tdo",         64'(TDO),             64'(m_tdo));
    chk("tdo_oe",      64'(TDO_OE),          64'(m_oe));
    chk("update_data", 64'(USR_UPDATE_DATA), 64'(m_upd));
    chk("capture_cnt", 64'(cap_seen),        64'(m_cap_n));
    chk("update_cnt",  64'(upd_seen),        64'(m_upd_n));
  endtask

  // ---------------- stimulus ----------------
  // One TCK period: 6 CLK low (outputs checked at the end), 6 CLK high.
  task automatic tick(input logic tms, input logic tdi, output logic tdo_s);
    @(negedge CLK);
    TMS = tms; TDI = tdi;
    repeat (5) @(negedge CLK);
    check_all();
    tdo_s = TDO;
    TCK = 1'b1;
    model_rise(tms, tdi);
    repeat (6) @(negedge CLK);
    TCK = 1'b0;
    model_fall();
  endtask

  task automatic tms_seq(input logic [15:0] bits, input int n);
    logic s;
    for (int i = 0; i < n; i++) tick(bits[i], 1'b0, s);
  endtask

  task automatic shift_bits(input logic [63:0] data, input int n, input logic exit_last,
                            output logic [63:0] tdo_v);
    logic s;
    tdo_v = '0;
    for (int i = 0; i < n; i++) begin
      tick(exit_last && (i == n - 1), data[i], s);
      tdo_v[i] = s;
    end
  endtask

  task automatic settle();
    repeat (6) @(negedge CLK);
  endtask

  // From Run-Test/Idle: load an instruction and return to Run-Test/Idle.
  task automatic load_ir(input logic [3:0] code, output logic [63:0] tdo_v);
    tms_seq(16'b0011, 4);            // SEL_DR, SEL_IR, CAP_IR, SHIFT_IR
    shift_bits(64'(code), 4, 1'b1, tdo_v);
    tms_seq(16'b01, 2);              // UPDATE_IR, IDLE
  endtask

  task automatic pulse_reset();
    settle();
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    model_reset();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int c0, u0;
    logic [34:0] d;
    logic [3:0] blk_ir [4];
    blk_ir[0] = 4'hA; blk_ir[1] = 4'hE; blk_ir[2] = 4'h3; blk_ir[3] = 4'hF;

    build_tables();
    m_cap_n = 0; m_upd_n = 0;
    model_reset();
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("reset_state",  64'(TAP_STATE), 64'h8);
    chk("reset_ir",     64'(IR_OUT), 64'hE);
    chk("reset_tdo_oe", 64'(TDO_OE), 64'h0);
    chk("reset_tdo",    64'(TDO), 64'h0);
    chk("reset_upd",    64'(USR_UPDATE_DATA), 64'h0);
    chk("reset_strobe", 64'(USR_CAPTURE | USR_UPDATE_VALID), 64'h0);
    $display("txn reset: state=%h ir=%h", TAP_STATE, IR_OUT);

    // IDCODE read
    tms_seq(16'b11111, 5);
    tms_seq(16'b0010, 4);            // IDLE, SEL_DR, CAP_DR, SHIFT_DR
    shift_bits(64'h0, 32, 1'b1, v);
    chk("idcode_tdo", v[31:0], 64'h1BA01477);
    settle();
    chk("idcode_exit1", 64'(TAP_STATE), 64'h5);
    $display("txn idcode: tdo=%h", v[31:0]);
    tms_seq(16'b01, 2);

    // IR all-ones -> BYPASS
    load_ir(4'hF, v);
    chk("ir_capture_tdo", v[3:0], 64'h1);
    settle();
    chk("ir_out_f", 64'(IR_OUT), 64'hF);
    tms_seq(16'b001, 3);             // SEL_DR, CAP_DR, SHIFT_DR
    shift_bits(64'h0A5, 9, 1'b1, v);
    chk("bypass_tdo", v[8:0], 64'h14A);
    $display("txn bypass: tdo=%h", v[8:0]);
    tms_seq(16'b01, 2);

    // User DR capture / update
    USR_CAPTURE_DATA = 35'h5_1234_5678;
    load_ir(4'hA, v);
    c0 = cap_seen; u0 = upd_seen;
    tms_seq(16'b001, 3);
    shift_bits(64'h4_DEAD_BEEF, 35, 1'b1, v);
    chk("user_tdo", v[34:0], 64'h5_1234_5678);
    tms_seq(16'b01, 2);
    settle();
    chk("user_update",  64'(USR_UPDATE_DATA), 64'h4_DEAD_BEEF);
    chk("user_cap_cnt", 64'(cap_seen - c0), 64'h1);
    chk("user_upd_cnt", 64'(upd_seen - u0), 64'h1);
    $display("txn user: tdo=%h upd=%h", v[34:0], USR_UPDATE_DATA);

    // User DR with a pause in the middle
    d = 35'h2_3456_789A;
    u0 = upd_seen;
    tms_seq(16'b001, 3);
    v = '0;
    for (int i = 0; i < 16; i++) begin
      logic s;
      tick(i == 15, d[i], s);
      v[i] = s;
    end
    tms_seq(16'b01000, 5);           // PAUSE x3 rises, EXIT2, SHIFT
    for (int i = 16; i < 35; i++) begin
      logic s;
      tick(i == 34, d[i], s);
      v[i] = s;
    end
    tms_seq(16'b01, 2);
    settle();
    chk("pause_update", 64'(USR_UPDATE_DATA), 64'h2_3456_789A);
    chk("pause_tdo",    v[34:0], 64'h5_1234_5678);
    chk("pause_upd_cnt", 64'(upd_seen - u0), 64'h1);
    $display("txn pause: upd=%h", USR_UPDATE_DATA);

    // Escape from Shift-DR with five TMS=1
    tms_seq(16'b001, 3);
    shift_bits(64'h5, 3, 1'b0, v);
    tms_seq(16'b11111, 5);
    settle();
    chk("escape_state", 64'(TAP_STATE), 64'h8);
    chk("escape_ir",    64'(IR_OUT), 64'hE);
    $display("txn escape: state=%h ir=%h", TAP_STATE, IR_OUT);

    // RESET mid Shift-DR
    tms_seq(16'b0, 1);
    load_ir(4'hA, v);
    tms_seq(16'b001, 3);
    shift_bits(64'h1B, 5, 1'b0, v);
    settle();
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    model_reset();
    chk("rst_state",  64'(TAP_STATE), 64'h8);
    chk("rst_tdo_oe", 64'(TDO_OE), 64'h0);
    chk("rst_ir",     64'(IR_OUT), 64'hE);
    chk("rst_upd",    64'(USR_UPDATE_DATA), 64'h0);
    $display("txn reset_mid_shift: state=%h ir=%h", TAP_STATE, IR_OUT);

    // Randomised blocks, each starting from a chosen instruction
    for (int b = 0; b < 4; b++) begin
      tms_seq(16'b011111, 6);        // reset, then IDLE
      load_ir(blk_ir[b], v);
      for (int t = 0; t < 150; t++) begin
        logic s;
        if ($urandom_range(0, 99) == 0) pulse_reset();
        if ($urandom_range(0, 15) == 0)
          USR_CAPTURE_DATA = 35'({$urandom(), $urandom()});
        tick($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), s);
      end
      settle();
      check_all();
      $display("txn random block %0d: ir=%h state=%h checks=%0d", b, IR_OUT, TAP_STATE, n_checks);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
